// File: rtl/calc_pkg.sv
// Shared types for the accumulator calculator and its command sequencer.
package calc_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    OR  = 2'd2,
    EQ  = 2'd3
  } calc_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STRIKE,
    S_CAPTURE,
    S_RESULT
  } seq_state_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the sequencer: power-of-two depth, registered occupancy count.
module calc_cmd_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 10
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wr_data,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Replays queued (op, operand) commands onto the calculator with a single-cycle
// Enter strike and hands each captured NumOut back through a valid/ready port.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic [1:0]               CmdOp,
  input  logic [WIDTH-1:0]         CmdNum,
  output logic                     Enter,
  output logic [WIDTH-1:0]         NumIn,
  output logic [1:0]               OpIn,
  input  logic [WIDTH-1:0]         NumOut,
  output logic                     ResValid,
  input  logic                     ResReady,
  output logic [WIDTH-1:0]         ResNum,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Busy
);

  seq_state_t         state;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WIDTH+1:0]   head;

  calc_cmd_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (WIDTH + 2)
  ) u_fifo (
    .clock   (clock),
    .Reset   (Reset),
    .push    (CmdValid),
    .pop     (pop),
    .wr_data ({CmdOp, CmdNum}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (Count)
  );

  assign CmdReady = !fifo_full;

  // Pops happen only from registered state, so a fresh push is never bypassed.
  assign pop = !fifo_empty && ((state == S_IDLE) || (state == S_RESULT && ResReady));

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      Enter    <= 1'b0;
      NumIn    <= '0;
      OpIn     <= '0;
      ResValid <= 1'b0;
      ResNum   <= '0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {OpIn, NumIn} <= head;
            state         <= S_SETUP;
            Busy          <= 1'b1;
          end
        end
        S_SETUP: begin
          Enter <= 1'b1;
          state <= S_STRIKE;
        end
        S_STRIKE: begin
          Enter <= 1'b0;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          ResNum   <= NumOut;
          ResValid <= 1'b1;
          state    <= S_RESULT;
        end
        S_RESULT: begin
          if (ResReady) begin
            ResValid <= 1'b0;
            if (pop) begin
              {OpIn, NumIn} <= head;
              state         <= S_SETUP;
            end else begin
              state <= S_IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          Enter <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
